// File: rtl/seq_shifter.sv
// Multi-cycle iterative shift/rotate unit: shifts by up to STEP bits per clock
// under a start/busy/done handshake. Rotate is natively left (ROL).
module seq_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  parameter int unsigned SAW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       shift_op,
  input  logic [SAW-1:0]   SA,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned KW = SAW + 1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SAW-1:0]   cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;

  logic [KW-1:0]    k_c;
  logic [KW-1:0]    rot_c;
  logic [SAW-1:0]   rem_c;
  logic [WIDTH-1:0] step_c;

  // One iteration: shift acc by k = min(STEP, cnt) so the last step never over-shifts.
  always_comb begin
    k_c    = (cnt_q < SAW'(STEP)) ? KW'(cnt_q) : KW'(STEP);
    rot_c  = KW'(WIDTH) - k_c;
    rem_c  = cnt_q - SAW'(k_c);
    step_c = acc_q;
    case (op_q)
      OP_SLL:  step_c = acc_q << k_c;
      OP_SRL:  step_c = acc_q >> k_c;
      OP_SRA:  step_c = WIDTH'($signed(acc_q) >>> k_c);
      OP_ROL:  step_c = (acc_q << k_c) | (acc_q >> rot_c);
      default: step_c = acc_q;
    endcase
  end

  // Next-state and datapath control; result is only written on entry to DONE.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          acc_d = data;
          op_d  = shift_op;
          cnt_d = SA;
          if (SA == '0) begin
            state_d  = S_DONE;
            result_d = data;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        acc_d = step_c;
        cnt_d = rem_c;
        if (rem_c == '0) begin
          state_d  = S_DONE;
          result_d = step_c;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= OP_SLL;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: one instance with STEP=1, one with STEP=4.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start4;
  logic [1:0]  shift_op_s;
  logic [4:0]  sa_s;
  logic [31:0] data_s;
  logic        busy1, done1, busy4, done4;
  logic [31:0] res1, res4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          bsy;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(32), .STEP(1), .SAW(5)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .shift_op(shift_op_s), .SA(sa_s),
    .data(data_s), .busy(busy1), .done(done1), .result(res1)
  );

  seq_shifter #(.WIDTH(32), .STEP(4), .SAW(5)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .shift_op(shift_op_s), .SA(sa_s),
    .data(data_s), .busy(busy4), .done(done4), .result(res4)
  );

  function automatic logic [31:0] model(input logic [1:0] op, input int sa, input logic [31:0] d);
    logic signed [31:0] s;
    s = d;
    case (op)
      2'b00:   return d << sa;
      2'b01:   return d >> sa;
      2'b10:   return 32'(s >>> sa);
      default: return (sa == 0) ? d : ((d << sa) | (d >> (32 - sa)));
    endcase
  endfunction

  // Drives one operation, pushes its expectation, and waits (bounded) for done.
  task automatic run_op(input bit sel, input logic [1:0] op, input int sa, input logic [31:0] d,
                        input bit chain, input bit mid, output logic [31:0] res,
                        output int lat, output int bcnt);
    exp_t e;
    int   step;
    step = sel ? 4 : 1;
    if (!chain) @(negedge clk);
    shift_op_s = op;
    sa_s       = 5'(sa);
    data_s     = d;
    if (sel) start4 = 1'b1; else start1 = 1'b1;
    e.res = model(op, sa, d);
    e.bsy = (sa + step - 1) / step;
    e.lat = 1 + e.bsy;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    data_s = $urandom; shift_op_s = 2'($urandom); sa_s = 5'($urandom);
    lat = 1; bcnt = 0;
    forever begin
      @(negedge clk);
      if (sel ? done4 : done1) break;
      if (sel ? busy4 : busy1) bcnt++;
      if (lat > 100) begin lat = -1; break; end
      if (mid && lat == 1) begin
        data_s = ~d;
        if (sel) start4 = 1'b1; else start1 = 1'b1;
      end
      @(posedge clk); #1;
      start1 = 1'b0; start4 = 1'b0;
      lat++;
    end
    res = sel ? res4 : res1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start1 = 1'b0; start4 = 1'b0;
    shift_op_s = 2'b00; sa_s = '0; data_s = '0;
    repeat (2) @(negedge clk);
    checks += 4;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL reset_ctl1 busy=%b done=%b want 0 0", busy1, done1); end
    if (res1 !== 32'h0) begin errors++; $display("FAIL reset_res1 got %h want 0", res1); end
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin errors++; $display("FAIL reset_ctl4 busy=%b done=%b want 0 0", busy4, done4); end
    if (res4 !== 32'h0) begin errors++; $display("FAIL reset_res4 got %h want 0", res4); end
    reset = 1'b0;
  endtask

  task automatic test_sll();
    logic [31:0] r; int lat, bc; exp_t e;
    run_op(1'b0, 2'b00, 31, 32'h0000_0001, 1'b0, 1'b0, r, lat, bc);
    e = sb_q.pop_front();
    checks += 4;
    if (r !== e.res || r !== 32'h8000_0000) begin errors++; $display("FAIL sll31_res got %h want %h", r, e.res); end
    if (lat != e.lat) begin errors++; $display("FAIL sll31_lat got %0d want %0d", lat, e.lat); end
    if (bc != e.bsy) begin errors++; $display("FAIL sll31_busy got %0d want %0d", bc, e.bsy); end
    @(negedge clk);
    if (done1 !== 1'b0 || res1 !== 32'h8000_0000) begin
      errors++; $display("FAIL sll31_hold done=%b res=%h want 0 80000000", done1, res1);
    end
  endtask

  task automatic test_sra_srl();
    logic [31:0] r; int lat, bc; exp_t e;
    logic [31:0] want[2];
    want[0] = 32'hF800_000F; want[1] = 32'h0800_000F;
    for (int i = 0; i < 2; i++) begin
      run_op(1'b0, (i == 0) ? 2'b10 : 2'b01, 4, 32'h8000_00F0, 1'b0, 1'b0, r, lat, bc);
      e = sb_q.pop_front();
      checks += 3;
      if (r !== e.res || r !== want[i]) begin errors++; $display("FAIL shr4_res[%0d] got %h want %h", i, r, want[i]); end
      if (lat != e.lat) begin errors++; $display("FAIL shr4_lat[%0d] got %0d want %0d", i, lat, e.lat); end
      if (bc != e.bsy) begin errors++; $display("FAIL shr4_busy[%0d] got %0d want %0d", i, bc, e.bsy); end
    end
  endtask

  task automatic test_rol();
    logic [31:0] r; int lat, bc; exp_t e;
    logic [31:0] want[2];
    want[0] = 32'h3456_7812; want[1] = 32'h7812_3456;
    for (int i = 0; i < 2; i++) begin
      run_op(1'b0, 2'b11, (i == 0) ? 8 : 24, 32'h1234_5678, 1'b0, 1'b0, r, lat, bc);
      e = sb_q.pop_front();
      checks += 2;
      if (r !== e.res || r !== want[i]) begin errors++; $display("FAIL rol_res[%0d] got %h want %h", i, r, want[i]); end
      if (lat != e.lat) begin errors++; $display("FAIL rol_lat[%0d] got %0d want %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_zero();
    logic [31:0] r; int lat, bc; exp_t e;
    for (int i = 0; i < 4; i++) begin
      run_op(i[0], 2'(i), 0, 32'hDEAD_BEEF, 1'b0, 1'b0, r, lat, bc);
      e = sb_q.pop_front();
      checks += 3;
      if (r !== e.res || r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sa0_res[%0d] got %h want deadbeef", i, r); end
      if (lat != 1) begin errors++; $display("FAIL sa0_lat[%0d] got %0d want 1", i, lat); end
      if (bc != 0) begin errors++; $display("FAIL sa0_busy[%0d] got %0d want 0", i, bc); end
    end
  endtask

  task automatic test_step4();
    logic [31:0] r; int lat, bc; exp_t e;
    run_op(1'b1, 2'b01, 7, 32'hFFFF_FFFF, 1'b0, 1'b1, r, lat, bc);
    e = sb_q.pop_front();
    checks += 3;
    if (r !== e.res || r !== 32'h01FF_FFFF) begin errors++; $display("FAIL step4_res got %h want 01ffffff", r); end
    if (lat != 3) begin errors++; $display("FAIL step4_lat got %0d want 3", lat); end
    if (bc != e.bsy) begin errors++; $display("FAIL step4_busy got %0d want %0d", bc, e.bsy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int lat, bc; exp_t e;
    run_op(1'b0, 2'b00, 3, 32'h0000_00A5, 1'b0, 1'b0, r, lat, bc);
    e = sb_q.pop_front();
    checks++;
    if (r !== e.res) begin errors++; $display("FAIL b2b_first got %h want %h", r, e.res); end
    run_op(1'b0, 2'b11, 5, 32'hF000_000F, 1'b1, 1'b0, r, lat, bc);
    e = sb_q.pop_front();
    checks += 2;
    if (r !== e.res) begin errors++; $display("FAIL b2b_second got %h want %h", r, e.res); end
    if (lat != e.lat) begin errors++; $display("FAIL b2b_lat got %0d want %0d", lat, e.lat); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    shift_op_s = 2'b00; sa_s = 5'd20; data_s = 32'h1; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks += 2;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL rstmid_ctl busy=%b done=%b want 0 0", busy1, done1); end
    if (res1 !== 32'h0) begin errors++; $display("FAIL rstmid_res got %h want 0", res1); end
    #2 reset = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done1 || busy1) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rstmid_abort got activity=1 want 0"); end
  endtask

  task automatic test_random();
    logic [31:0] r; int lat, bc; exp_t e;
    for (int i = 0; i < 16; i++) begin
      run_op(i[0], 2'($urandom), int'($urandom_range(0, 31)), $urandom, 1'b0, 1'b0, r, lat, bc);
      e = sb_q.pop_front();
      checks += 3;
      if (r !== e.res) begin errors++; $display("FAIL rand_res[%0d] got %h want %h", i, r, e.res); end
      if (lat != e.lat) begin errors++; $display("FAIL rand_lat[%0d] got %0d want %0d", i, lat, e.lat); end
      if (bc != e.bsy) begin errors++; $display("FAIL rand_busy[%0d] got %0d want %0d", i, bc, e.bsy); end
    end
  endtask

  initial begin
    test_reset();
    test_sll();
    test_sra_srl();
    test_rol();
    test_zero();
    test_step4();
    test_back_to_back();
    test_reset_mid();
    test_random();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
